fp16_accum: RTL and testbench

Sequential FP16 accumulator that consumes the product stream of the FP16 multiplier. It sums a programmed number of terms (a dot-product reduction) and returns one FP16 result through a valid/ready output handshake. It uses the same number-format policy as the multiplier: subnormals flush to zero, exponent 31 clamps to infinity, and NaN is never produced.

---
 rtl/fp16_pkg.sv | 18 +
 rtl/fp16_add_core.sv | 93 +++++++++
 rtl/fp16_accum.sv | 98 +++++++++
 tb/tb_fp16_accum.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 format constants and accumulator state encoding.
package fp16_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MANT_W   = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] POS_INF  = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fp16_add_core.sv
// Combinational FP16 adder: flush-to-zero, exp 31 as infinity, RNE, never NaN.
module fp16_add_core
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  localparam int unsigned SIG_W = MANT_W + 1;
  localparam int unsigned EXT_W = SIG_W + 3;
  localparam int unsigned SHF_W = SIG_W + 13;

  logic              sa, sb, a_zero, b_zero, a_inf, b_inf, swap;
  logic [EXP_W-1:0]  ea, eb, el, es, diff;
  logic [MANT_W-1:0] ma, mb, ml, ms;
  logic              sl;
  logic [3:0]        shamt, lz;
  logic [SHF_W-1:0]  shifted;
  logic [EXT_W-1:0]  l_ext, s_ext, norm;
  logic [EXT_W:0]    sum;
  logic              round_up;
  logic [MANT_W:0]   mant_r;
  logic signed [6:0] e_norm, e_fin;

  assign sa = a[15];
  assign sb = b[15];
  assign ea = a[14:10];
  assign eb = b[14:10];
  assign ma = a[9:0];
  assign mb = b[9:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX);
  assign b_inf  = (eb == EXP_MAX);
  assign swap   = (b[14:0] > a[14:0]);

  // Datapath for two normal operands: align, add/sub, normalise, round.
  always_comb begin
    sl = swap ? sb : sa;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;

    diff    = el - es;
    shamt   = (diff > 5'd13) ? 4'd13 : diff[3:0];
    shifted = {1'b1, ms, 13'd0} >> shamt;
    l_ext   = {1'b1, ml, 3'b000};
    s_ext   = {shifted[SHF_W-1:13], shifted[12], shifted[11], |shifted[10:0]};

    if (sa == sb) sum = {1'b0, l_ext} + {1'b0, s_ext};
    else          sum = {1'b0, l_ext} - {1'b0, s_ext};

    lz = 4'd0;
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (sum[i]) lz = 4'(int'(EXT_W) - 1 - i);
    end

    if (sum[EXT_W]) begin
      norm   = {sum[EXT_W:2], |sum[1:0]};
      e_norm = $signed({2'b00, el}) + 7'sd1;
    end else begin
      norm   = sum[EXT_W-1:0] << lz;
      e_norm = $signed({2'b00, el}) - $signed({3'b000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[12:3]} + {10'd0, round_up};
    e_fin    = e_norm + $signed({6'd0, mant_r[MANT_W]});

    y = {sl, e_fin[4:0], mant_r[MANT_W-1:0]};
    if (a_inf || b_inf) begin
      if (a_inf && b_inf && (sa != sb)) y = POS_INF;
      else if (a_inf)                   y = {sa, EXP_MAX, 10'd0};
      else                              y = {sb, EXP_MAX, 10'd0};
    end else if (a_zero && b_zero) begin
      y = {sa & sb, 15'd0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if (!norm[EXT_W-1]) begin
      y = POS_ZERO;
    end else if (e_fin >= 7'sd31) begin
      y = {sl, EXP_MAX, 10'd0};
    end else if (e_fin <= 7'sd0) begin
      y = {sl, 15'd0};
    end
  end

endmodule

// File: rtl/fp16_accum.sv
// Sequential FP16 reduction of a programmed number of terms with valid/ready I/O.
module fp16_accum
  import fp16_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d, out_data_q, out_data_d, sum_c;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             in_ready_q, out_valid_q, busy_q;

  fp16_add_core u_add (
    .a (acc_q),
    .b (in_data),
    .y (sum_c)
  );

  // Next-state, counter and datapath register updates.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            acc_d   = POS_ZERO;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            out_data_d = POS_ZERO;
            state_d    = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            out_data_d = sum_c;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= POS_ZERO;
      cnt_q       <= '0;
      len_q       <= '0;
      out_data_q  <= POS_ZERO;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp16_accum.sv
// Scoreboard bench for fp16_accum: arithmetic cases, gaps, backpressure, zero length, reset.
module tb_fp16_accum;

  localparam int unsigned CNT_W = 9;

  logic             clk, rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [CNT_W-1:0] len;
  logic [15:0]      in_data, out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] term_q[$];

  fp16_accum #(.MAX_LEN(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One accumulation: expected result queued at start, compared at the output handshake.
  task automatic run_job(input string tag, input int n, input logic [15:0] exp_v,
                         input bit gapped, input int hold, input bit poke);
    logic [5:0] pat;
    logic       rdy;
    int         taken, cyc, gi;
    pat = 6'b101101;
    exp_q.push_back(exp_v);
    start = 1'b1;
    len   = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    taken = 0; cyc = 0; gi = 0;
    while (taken < n && cyc < 100) begin
      in_valid = gapped ? pat[5 - (gi % 6)] : 1'b1;
      in_data  = term_q[taken];
      rdy      = in_ready;
      gi++;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && rdy) taken++;
    end
    in_valid = 1'b0;
    if (cyc >= 100) check_eq({tag, "_timeout"}, 32'(taken), 32'(n));
    if (gapped) check_eq({tag, "_cycles"}, 32'(cyc), 32'd6);
    check_eq({tag, "_latency"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = poke;
      len   = CNT_W'(1);
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(out_data), 32'(exp_q[0]));
    end
    start     = poke;
    len       = CNT_W'(1);
    out_ready = 1'b1;
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    term_q = '{16'h3C00, 16'h4000};
    run_job("one_plus_two", 2, 16'h4200, 1'b0, 0, 1'b0);
    term_q = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    run_job("gapped4", 4, 16'h4400, 1'b1, 0, 1'b0);
    term_q = '{16'h3C00, 16'h1000};
    run_job("rne_tie_even", 2, 16'h3C00, 1'b0, 0, 1'b0);
    term_q = '{16'h3C01, 16'h1000};
    run_job("rne_tie_up", 2, 16'h3C02, 1'b0, 0, 1'b0);
    term_q = '{16'h3C00, 16'hBC00};
    run_job("cancel", 2, 16'h0000, 1'b0, 0, 1'b0);
    term_q = '{16'h7BFF, 16'h7BFF};
    run_job("overflow", 2, 16'h7C00, 1'b0, 0, 1'b0);
    term_q = '{16'h0001, 16'h3C00};
    run_job("sub_flush", 2, 16'h3C00, 1'b0, 0, 1'b0);
    term_q = '{16'h7C00, 16'hFC00};
    run_job("inf_opp", 2, 16'h7C00, 1'b0, 0, 1'b0);
    // acc starts at +0, so +0 + -0 + -0 stays +0
    term_q = '{16'h8000, 16'h8000};
    run_job("neg_zeros", 2, 16'h0000, 1'b0, 0, 1'b0);
    term_q = '{16'h3C00, 16'h3C00};
    run_job("backpressure", 2, 16'h4000, 1'b0, 3, 1'b1);
    term_q.delete();
    run_job("len_zero", 0, 16'h0000, 1'b0, 0, 1'b0);

    start = 1'b1;
    len   = CNT_W'(4);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    term_q = '{16'h4000};
    run_job("post_rst", 1, 16'h4000, 1'b0, 0, 1'b0);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
